// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC register, IF/ID pipeline register, RUN/HALT fetch control
// Optional perf counters (fetch_count, stall_count) enabled by defining FETCH_PERF_EN.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 88
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic [31:0] instruction,
    output logic [63:0] inst_address,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);
    localparam logic [31:0] NOP       = 32'h00000013;

    typedef enum logic {RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [63:0] pc_seq;
    logic [63:0] br_pc;

    assign pc_seq = pc_q + 64'd4;
    assign br_pc  = branch_target & ~64'd3;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;

        if (branch_taken) begin
            // A redirect flushes IF/ID in either state; the target alone decides RUN vs HALT.
            pc_d          = br_pc;
            if_id_pc_d    = 64'h0;
            if_id_instr_d = NOP;
            if_id_valid_d = 1'b0;
            state_d       = (br_pc >= MEM_LIMIT) ? HALT : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        pc_d          = pc_seq;
                        if_id_pc_d    = pc_q;
                        if_id_instr_d = instruction;
                        if_id_valid_d = 1'b1;
                        if (pc_seq >= MEM_LIMIT) begin
                            state_d = HALT;
                        end
                    end
                end
                HALT: begin
                    if_id_pc_d    = 64'h0;
                    if_id_instr_d = NOP;
                    if_id_valid_d = 1'b0;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign inst_address      = pc_q;
    assign if_id_pc          = if_id_pc_q;
    assign if_id_instruction = if_id_instr_q;
    assign if_id_valid       = if_id_valid_q;
    assign halted            = (state_q == HALT);

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        fetch_hit;
    logic        stall_hit;

    always_comb begin
        fetch_hit     = (state_q == RUN) && !branch_taken && !stall;
        stall_hit     = (state_q == RUN) && !branch_taken && stall;
        fetch_count_d = fetch_count_q;
        stall_count_d = stall_count_q;
        // Counters stick at all-ones rather than wrapping.
        if (fetch_hit && (fetch_count_q != 32'hFFFFFFFF)) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (stall_hit && (stall_count_q != 32'hFFFFFFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= 32'h0;
            stall_count_q <= 32'h0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed table-driven bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] instruction;
    logic [63:0] inst_address;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int n_total = 0;
    int n_pass  = 0;

    instruction_fetch #(.RESET_PC(64'h0), .MEM_BYTES(88)) dut (
        .clk               (clk),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .instruction       (instruction),
        .inst_address      (inst_address),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .halted            (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count       (fetch_count),
        .stall_count       (stall_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int idx);
        if (idx == 2) return 32'h04b40863;
        return 32'h00000013 + (32'(idx) << 7);
    endfunction

    always_comb begin
        if (inst_address < 64'd88) instruction = mem_word(int'(inst_address[6:2]));
        else                       instruction = 32'hDEADBEEF;
    end

    typedef struct {
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] pc;
        logic [63:0] ipc;
        logic [31:0] ins;
        logic        v;
        logic        h;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic chk_all(input string tag, input logic [63:0] pc, input logic [63:0] ipc,
                           input logic [31:0] ins, input logic v, input logic h);
        chk({tag, ".inst_address"}, inst_address, pc);
        chk({tag, ".if_id_pc"}, if_id_pc, ipc);
        chk({tag, ".if_id_instruction"}, 64'(if_id_instruction), 64'(ins));
        chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(v));
        chk({tag, ".halted"}, 64'(halted), 64'(h));
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [63:0] t,
                                input logic [63:0] pc, input logic [63:0] ipc,
                                input logic [31:0] ins, input logic v, input logic h);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.pc = pc; r.ipc = ipc; r.ins = ins; r.v = v; r.h = h;
        return r;
    endfunction

    localparam logic [31:0] NOP = 32'h00000013;

    initial begin
        vecs[0]  = mk(0, 0, 0,        64'd4,   64'd0,  mem_word(0),  1, 0);
        vecs[1]  = mk(0, 0, 0,        64'd8,   64'd4,  mem_word(1),  1, 0);
        vecs[2]  = mk(0, 0, 0,        64'd12,  64'd8,  32'h04b40863, 1, 0);
        vecs[3]  = mk(0, 0, 0,        64'd16,  64'd12, mem_word(3),  1, 0);
        vecs[4]  = mk(1, 0, 0,        64'd16,  64'd12, mem_word(3),  1, 0);
        vecs[5]  = mk(1, 0, 0,        64'd16,  64'd12, mem_word(3),  1, 0);
        vecs[6]  = mk(0, 0, 0,        64'd20,  64'd16, mem_word(4),  1, 0);
        vecs[7]  = mk(1, 1, 64'h2E,   64'd44,  64'd0,  NOP,          0, 0);
        vecs[8]  = mk(0, 0, 0,        64'd48,  64'd44, mem_word(11), 1, 0);
        vecs[9]  = mk(0, 1, 64'd84,   64'd84,  64'd0,  NOP,          0, 0);
        vecs[10] = mk(0, 0, 0,        64'd88,  64'd84, mem_word(21), 1, 1);
        vecs[11] = mk(0, 0, 0,        64'd88,  64'd0,  NOP,          0, 1);
        vecs[12] = mk(1, 0, 0,        64'd88,  64'd0,  NOP,          0, 1);
        vecs[13] = mk(0, 1, 64'd8,    64'd8,   64'd0,  NOP,          0, 0);
        vecs[14] = mk(0, 0, 0,        64'd12,  64'd8,  32'h04b40863, 1, 0);
        vecs[15] = mk(0, 1, 64'h100,  64'h100, 64'd0,  NOP,          0, 1);
        vecs[16] = mk(0, 1, 64'h27,   64'd36,  64'd0,  NOP,          0, 0);
        vecs[17] = mk(0, 0, 0,        64'd40,  64'd36, mem_word(9),  1, 0);

        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 64'd0, 64'd0, NOP, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            stall = vecs[i].stall;
            branch_taken = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ipc, vecs[i].ins, vecs[i].v, vecs[i].h);
            @(negedge clk);
        end

        // Asynchronous reset mid-cycle with stall and branch asserted.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 64'd8;
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 64'd0, 64'd0, NOP, 0, 0);
`ifdef FETCH_PERF_EN
        chk("perf_reset.fetch_count", 64'(fetch_count), 64'd0);
        chk("perf_reset.stall_count", 64'(stall_count), 64'd0);
`endif
        @(posedge clk);
        #1;
        chk_all("reset_hold", 64'd0, 64'd0, NOP, 0, 0);
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0; branch_target = 64'h0;
        reset = 1'b1;

        // 10 fetches then 3 stall cycles.
        repeat (10) @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        stall = 1'b0;
        #1;
        chk_all("perf_seq", 64'd40, 64'd36, mem_word(9), 1, 0);
`ifdef FETCH_PERF_EN
        chk("perf.fetch_count", 64'(fetch_count), 64'd10);
        chk("perf.stall_count", 64'(stall_count), 64'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, sets the first fetch address after reset.
REQ-002 Parameter MEM_BYTES, default 88, sets the instruction memory size in bytes; the last valid word starts at MEM_BYTES-4.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard stall from decode; holds PC and IF/ID.
REQ-006 branch_taken  input  1  redirect request from execute.
REQ-007 branch_target  input  64  redirect byte address.
REQ-008 instruction  input  32  word returned combinationally by instruction memory for inst_address.
REQ-009 inst_address  output  64  fetch byte address driven to instruction memory; equals current PC.
REQ-010 if_id_pc  output  64  PC of the instruction held in IF/ID.
REQ-011 if_id_instruction  output  32  instruction held in IF/ID.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-013 halted  output  1  PC has left the memory range; fetch has stopped.

Function
REQ-014 The block has two states: RUN (fetching) and HALT (PC out of range).
REQ-015 inst_address is combinational from the PC register, with zero latency to the memory.
REQ-016 In RUN with stall=0 and branch_taken=0, each edge loads IF/ID with {PC, instruction, valid=1} and sets PC to PC+4 (64-bit, wrap-around modulo 2^64).
REQ-017 With stall=1 and branch_taken=0, PC and all IF/ID outputs hold their values.
REQ-018 branch_taken=1 has priority over stall: PC loads {branch_target[63:2],2'b00}, if_id_instruction loads 32'h00000013 (NOP), if_id_valid loads 0, and if_id_pc loads 0.
REQ-019 A misaligned branch_target has its two LSBs forced to zero; no error is raised.
REQ-020 RUN transitions to HALT when a non-stalled, non-branch edge would set PC to a value at or above MEM_BYTES; PC still updates, and the word at MEM_BYTES-4 is registered normally.
REQ-021 In HALT, IF/ID loads the NOP with valid=0 each edge, halted=1, and PC holds its value.
REQ-022 branch_taken=1 in HALT to a target below MEM_BYTES returns the block to RUN, with the flush per REQ-018; a target at or above MEM_BYTES keeps the block in HALT.
REQ-023 A branch in RUN to a target at or above MEM_BYTES enters HALT on that edge.
REQ-024 Outputs change only at a clock edge or on reset assertion; apart from inst_address, the block has no combinational path from inputs to outputs.

Reset
REQ-025 On reset=0, asynchronously: PC=RESET_PC, state=RUN, if_id_pc=0, if_id_instruction=32'h00000013, if_id_valid=0, halted=0.
REQ-026 After reset deasserts, the first edge registers the instruction at RESET_PC.
REQ-027 Reset asserted mid-stall or mid-branch overrides all other inputs immediately.

Configuration
REQ-028 When macro FETCH_PERF_EN is defined, the block adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
REQ-029 With FETCH_PERF_EN defined, fetch_count increments on every edge that loads if_id_valid=1, and stall_count increments on every edge with stall=1 and branch_taken=0 in RUN.
REQ-030 Both counters saturate at 32'hFFFFFFFF.
REQ-031 Without FETCH_PERF_EN, the counter ports and logic are absent, and all other behaviour is identical.

Verification
REQ-032 Reset then 3 free-running edges -> inst_address 0,4,8,12; IF/ID holds PC 8 with instruction 32'h04b40863 and valid=1.
REQ-033 stall=1 for 2 cycles at PC=16 -> inst_address stays 16 and IF/ID is unchanged; on release, IF/ID loads PC 16 on the next edge.
REQ-034 stall=1 and branch_taken=1 with target 64'h2E in the same cycle -> PC=44, IF/ID={0, 32'h00000013, valid 0}.
REQ-035 Free-run from PC 84 -> IF/ID loads word 84 with valid=1 and halted=1; subsequent edges give valid=0 and PC=88; a branch to 8 clears halted and fetch resumes at 8.
REQ-036 Reset pulsed low between edges while PC=40 -> outputs take reset values immediately with no clock.
REQ-037 With FETCH_PERF_EN: 10 fetches and 3 stall cycles -> fetch_count=10 and stall_count=3.
